// File: rtl/simon_seq_player.sv
// simon_seq_player
// Sequence generator and playback stage for the Simon Says game.
// Holds the current level and a 16-bit LFSR seed. On each playback it
// regenerates the colour sequence from that seed and shows it on a one-hot
// LED bus: ON_CYCLES lit cycles, then OFF_CYCLES dark cycles per element.
// Optional build macro: SIMON_FIXED_SEED_EN. When it is defined, every new
// game uses the fixed SEED, so the sequence is deterministic.
module simon_seq_player #(
    parameter int          MAX_LEN    = 16,
    parameter int          ON_CYCLES  = 8,
    parameter int          OFF_CYCLES = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         play,
    input  logic                         advance,
    output logic [3:0]                   led,
    output logic [1:0]                   seq_color,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         busy,
    output logic                         done,
    output logic                         full
);

    localparam int LW     = $clog2(MAX_LEN + 1);
    localparam int TMAX   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [LW-1:0] LVL_ZERO = '0;
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_MAX  = LW'(MAX_LEN);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ON,
        S_OFF
    } state_t;

    state_t          state_reg;
    logic [15:0]     free_s_reg;
    logic [15:0]     seed_reg;
    logic [15:0]     play_s_reg;
    logic [LW-1:0]   level_reg;
    logic [LW-1:0]   idx_reg;
    logic [TW-1:0]   timer_reg;
    logic            start_q_reg;
    logic [3:0]      led_reg;
    logic [1:0]      color_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            full_reg;

    logic            rise;
    logic [15:0]     seed_src;
    logic [15:0]     play_step;
    logic [LW-1:0]   level_inc;
    logic [3:0]      load_onehot;
    logic [3:0]      next_onehot;

    // One LFSR step: taps 16,14,13,11, shifting left
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign rise      = start & ~start_q_reg;
    assign play_step = lfsr_step(play_s_reg);
    assign level_inc = level_reg + LVL_ONE;

`ifdef SIMON_FIXED_SEED_EN
    assign seed_src = SEED;
`else
    assign seed_src = free_s_reg;
`endif

    // One-hot colour decode for the first element (from the seed) and for the next element
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_onehot
            assign load_onehot[gi] = (seed_reg[1:0] == 2'(gi));
            assign next_onehot[gi] = (play_step[1:0] == 2'(gi));
        end
    endgenerate

    // Free-running LFSR; its value at a start edge becomes the game seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_s_reg <= SEED;
        end else begin
            free_s_reg <= lfsr_step(free_s_reg);
        end
    end

    // Game/playback FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            seed_reg    <= SEED;
            play_s_reg  <= '0;
            level_reg   <= LVL_ZERO;
            idx_reg     <= LVL_ZERO;
            timer_reg   <= '0;
            start_q_reg <= 1'b0;
            led_reg     <= 4'b0000;
            color_reg   <= 2'b00;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            full_reg    <= 1'b0;
        end else begin
            start_q_reg <= start;
            done_reg    <= 1'b0;
            if (rise) begin
                // A new game aborts whatever is running; no done pulse
                seed_reg  <= seed_src;
                level_reg <= LVL_ONE;
                full_reg  <= (LVL_ONE == LVL_MAX);
                led_reg   <= 4'b0000;
                busy_reg  <= 1'b1;
                state_reg <= S_LOAD;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (play) begin
                            if (level_reg != LVL_ZERO) begin
                                busy_reg  <= 1'b1;
                                state_reg <= S_LOAD;
                            end
                        end else if (advance) begin
                            if (level_reg != LVL_MAX) begin
                                level_reg <= level_inc;
                                full_reg  <= (level_inc == LVL_MAX);
                            end
                        end
                    end
                    S_LOAD: begin
                        // Light the first element on the LOAD->ON edge
                        play_s_reg <= seed_reg;
                        idx_reg    <= LVL_ZERO;
                        timer_reg  <= '0;
                        led_reg    <= load_onehot;
                        color_reg  <= seed_reg[1:0];
                        state_reg  <= S_ON;
                    end
                    S_ON: begin
                        if (timer_reg == ON_LAST) begin
                            timer_reg <= '0;
                            led_reg   <= 4'b0000;
                            state_reg <= S_OFF;
                        end else begin
                            timer_reg <= timer_reg + TMR_ONE;
                        end
                    end
                    S_OFF: begin
                        if (timer_reg == OFF_LAST) begin
                            timer_reg <= '0;
                            if (idx_reg == level_reg - LVL_ONE) begin
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                state_reg <= S_IDLE;
                            end else begin
                                idx_reg    <= idx_reg + LVL_ONE;
                                play_s_reg <= play_step;
                                led_reg    <= next_onehot;
                                color_reg  <= play_step[1:0];
                                state_reg  <= S_ON;
                            end
                        end else begin
                            timer_reg <= timer_reg + TMR_ONE;
                        end
                    end
                    default: begin
                        led_reg   <= 4'b0000;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign led       = led_reg;
    assign seq_color = color_reg;
    assign level     = level_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign full      = full_reg;

endmodule

// File: tb/tb_simon_seq_player.sv
// Testbench for simon_seq_player: a per-cycle scoreboard of expected
// {led, seq_color, busy, done, level, full}, with table-driven advance steps.
module tb_simon_seq_player;

    localparam int          MAX_LEN = 16;
    localparam int          ON_C    = 8;
    localparam int          OFF_C   = 4;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          play;
    logic          advance;
    logic [3:0]    led;
    logic [1:0]    seq_color;
    logic [LW-1:0] level;
    logic          busy;
    logic          done;
    logic          full;

    simon_seq_player #(
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .SEED       (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .play      (play),
        .advance   (advance),
        .led       (led),
        .seq_color (seq_color),
        .level     (level),
        .busy      (busy),
        .done      (done),
        .full      (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    led;
        logic [1:0]    col;
        logic          busy;
        logic          done;
        logic [LW-1:0] lvl;
        logic          full;
    } exp_t;

    typedef struct {
        logic          do_play;
        logic [LW-1:0] lvl;
        logic          full;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[21];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    string         tag   = "init";
    logic [LW-1:0] exp_level = '0;
    logic          exp_full  = 1'b0;
    logic [15:0]   ref_free;
    logic [15:0]   g_seed;
    logic [15:0]   seed2;
    logic [15:0]   seed3;
    logic [15:0]   tmp_s;
    logic [1:0]    c2;

    function automatic logic [15:0] lfsr(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference free-running generator, same reset and stepping as the game clock
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_free <= SEED;
        else        ref_free <= lfsr(ref_free);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Seed the DUT will capture if start rises at the next edge
    function automatic logic [15:0] game_seed();
`ifdef SIMON_FIXED_SEED_EN
        return SEED;
`else
        return ref_free;
`endif
    endfunction

    task automatic push(input logic [3:0] l, input logic [1:0] c, input logic b, input logic d);
        exp_t e;
        e.led = l; e.col = c; e.busy = b; e.done = d; e.lvl = exp_level; e.full = exp_full;
        sb.push_back(e);
    endtask

    task automatic push_idle();
        push(4'b0000, 2'b00, 1'b0, 1'b0);
    endtask

    // LOAD cycle, then every lit/dark cycle of n elements, then the done cycle
    task automatic push_playback(input logic [15:0] s0, input int n);
        logic [15:0] s;
        logic [1:0]  c;
        s = s0;
        push(4'b0000, 2'b00, 1'b1, 1'b0);
        for (int e = 0; e < n; e++) begin
            c = s[1:0];
            for (int k = 0; k < ON_C; k++)  push(4'b0001 << c, c, 1'b1, 1'b0);
            for (int k = 0; k < OFF_C; k++) push(4'b0000, 2'b00, 1'b1, 1'b0);
            s = lfsr(s);
        end
        push(4'b0000, 2'b00, 1'b0, 1'b1);
    endtask

    // Compare one cycle at the falling edge, then clear single-cycle pulses
    task automatic step_check();
        exp_t e;
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (led !== e.led || busy !== e.busy || done !== e.done || level !== e.lvl ||
            full !== e.full || (e.led != 4'b0000 && seq_color !== e.col)) begin
            bad++;
            $display("FAIL %s cyc=%0d got led=%b col=%0d busy=%b done=%b level=%0d full=%b want led=%b col=%0d busy=%b done=%b level=%0d full=%b",
                     tag, cyc, led, seq_color, busy, done, level, full,
                     e.led, e.col, e.busy, e.done, e.lvl, e.full);
        end else begin
            $display("ok   %s cyc=%0d led=%b col=%0d busy=%b done=%b level=%0d full=%b",
                     tag, cyc, led, seq_color, busy, done, level, full);
        end
        @(posedge clk);
        #1;
        play    = 1'b0;
        advance = 1'b0;
    endtask

    task automatic drain();
        while (sb.size() > 0) step_check();
    endtask

    task automatic check_zero(input string name);
        total++;
        if (led !== 4'b0000 || seq_color !== 2'b00 || level !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL %s got led=%b col=%0d level=%0d busy=%b done=%b full=%b want all zero",
                     name, led, seq_color, level, busy, done, full);
        end else begin
            $display("ok   %s all outputs zero", name);
        end
    endtask

    initial begin
        // Advance table: the level climbs from 1 and saturates at MAX_LEN
        for (int i = 0; i < 21; i++) begin
            vecs[i].lvl     = LW'((i + 2 > MAX_LEN) ? MAX_LEN : i + 2);
            vecs[i].full    = (i + 2 >= MAX_LEN);
            vecs[i].do_play = (i == 1);
        end

        rst_n = 1'b0; start = 1'b0; play = 1'b0; advance = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // play with level 0 is ignored
        tag = "play_lvl0";
        play = 1'b1;
        repeat (4) push_idle();
        drain();

        // New game: level 1, one element
        tag = "start1";
        start = 1'b1;
        g_seed = game_seed();
        push_idle();
        exp_level = LW'(1);
        exp_full  = 1'b0;
        push_playback(g_seed, 1);
        push_idle();
        drain();

        // Advances; after reaching level 3, replay with ignored pulses while busy
        for (int i = 0; i < 21; i++) begin
            tag = "advance";
            advance = 1'b1;
            push_idle();
            exp_level = vecs[i].lvl;
            exp_full  = vecs[i].full;
            push_idle();
            drain();
            if (vecs[i].do_play) begin
                tag = "play3";
                play = 1'b1;
                push_idle();
                push_playback(g_seed, 3);
                push_idle();
                repeat (6) step_check();
                play = 1'b1; advance = 1'b1;
                repeat (10) step_check();
                play = 1'b1; advance = 1'b1;
                drain();
            end
        end

        // Restart from the saturated level, then build level 2
        tag = "restart";
        start = 1'b0;
        push_idle();
        step_check();
        start = 1'b1;
        seed2 = game_seed();
        push_idle();
        exp_level = LW'(1);
        exp_full  = 1'b0;
        push_playback(seed2, 1);
        push_idle();
        drain();

        tag = "advance2";
        advance = 1'b1;
        push_idle();
        exp_level = LW'(2);
        push_idle();
        drain();

        // Abort during the second element's ON phase
        tag = "abort";
        play = 1'b1;
        push_idle();
        push_playback(seed2, 2);
        repeat (16) step_check();
        sb.delete();
        tmp_s = lfsr(seed2);
        c2 = tmp_s[1:0];
        start = 1'b0;
        push(4'b0001 << c2, c2, 1'b1, 1'b0);
        step_check();
        start = 1'b1;
        seed3 = game_seed();
        push(4'b0001 << c2, c2, 1'b1, 1'b0);
        exp_level = LW'(1);
        push_playback(seed3, 1);
        push_idle();
        drain();

        // Asynchronous reset in the middle of a lit element
        tag = "rst_mid_on";
        play = 1'b1;
        push_idle();
        push_playback(seed3, 1);
        repeat (5) step_check();
        sb.delete();
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tag = "post_rst";
        exp_level = '0;
        exp_full  = 1'b0;
        repeat (3) push_idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
